// File: rtl/piso_tx_arbiter_if.sv
// Requester and shifter-side bundle for piso_tx_arbiter.
// Ports: enable, req_valid/req_data/req_ready, piso_load/piso_data, framing.
interface piso_tx_arbiter_if #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 2,
    parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic                     enable;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     piso_load;
    logic [WIDTH-1:0]         piso_data;
    logic                     ser_valid;
    logic                     ser_last;
    logic [GW-1:0]            grant_id;
    logic                     busy;

    modport master (
        output enable, req_valid, req_data,
        input  req_ready, piso_load, piso_data,
        input  ser_valid, ser_last, grant_id, busy
    );

    modport slave (
        input  enable, req_valid, req_data,
        output req_ready, piso_load, piso_data,
        output ser_valid, ser_last, grant_id, busy
    );
endinterface

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter/sequencer feeding a shared WIDTH-bit PISO shifter.
// Ports: clk, rst_n (async low), bus (slave: requesters in, shifter/framing out).
module piso_tx_arbiter #(
    parameter int WIDTH      = 4,
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_tx_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    gcnt, gcnt_nxt;
    logic [GW-1:0] ptr, ptr_nxt;
    logic [GW-1:0] winner, idx;
    logic          found, grant;
    logic          sv_q, sl_q, busy_q;
    logic [GW-1:0] gid_q;
    int            j;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        j      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = GW'(j);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Gated by rst_n so the combinational handshake drops with reset.
    assign grant = rst_n && (state == IDLE) && bus.enable && found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            gcnt   <= '0;
            ptr    <= '0;
            sv_q   <= 1'b0;
            sl_q   <= 1'b0;
            busy_q <= 1'b0;
            gid_q  <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            gcnt   <= gcnt_nxt;
            ptr    <= ptr_nxt;
            // The edge after the load re-presents the MSB, so no valid.
            sv_q   <= grant || (state == SHIFT && cnt != '0);
            sl_q   <= (state == SHIFT) && (cnt == CW'(WIDTH - 1));
            busy_q <= grant || (state == SHIFT);
            if (grant) gid_q <= winner;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gcnt_nxt  = gcnt;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    ptr_nxt   = (winner == GW'(NUM_REQ - 1)) ?
                                '0 : winner + GW'(1);
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    cnt_nxt   = '0;
                    gcnt_nxt  = '0;
                    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            GAP: begin
                if (gcnt == 4'(GAP_CYCLES - 1)) begin
                    gcnt_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    gcnt_nxt = gcnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.piso_load = grant;
        bus.piso_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant && winner == GW'(k)) begin
                bus.req_ready[k] = 1'b1;
                bus.piso_data    = bus.req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.ser_valid = sv_q;
    assign bus.ser_last  = sl_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = gid_q;
endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Scoreboard bench for piso_tx_arbiter (GAP 0 main DUT, GAP 2 side DUT).
// Reference model works in cycle numbers and rr order, not RTL state.
module tb_piso_tx_arbiter;
    localparam int W = 4;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_tx_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) a ();
    piso_tx_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) b ();

    piso_tx_arbiter #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(a)
    );
    piso_tx_arbiter #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(2)) dut_gap (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // External shifter: registered data_out, load shows MSB, then shifts.
    logic [W-1:0] sh = '0;
    logic dout = 1'b0;
    always @(posedge clk) begin
        if (a.piso_load) begin
            sh   <= a.piso_data;
            dout <= a.piso_data[W-1];
        end else begin
            sh   <= sh << 1;
            dout <= sh[W-1];
        end
    end

    typedef struct { int id; logic [W-1:0] data; } gexp_t;
    typedef struct { logic bit_v; logic last; } bexp_t;
    gexp_t gq[$];
    bexp_t bq[$];

    int ptr = 0, free_at = 0, last_load = -100;
    int gid_now = 0, gid_last = 0;
    logic [N-1:0] exp_ready = '0;
    logic [N-1:0] hs = '0;
    logic exp_load = 1'b0, exp_busy = 1'b0;

    // Reference model: a word occupies W+1 cycles; next load is legal
    // from free_at on; rr picks first valid at or after ptr.
    always @(negedge clk) begin
        int win, id;
        logic [W-1:0] d;
        hs = a.req_valid & a.req_ready;
        exp_ready = '0;
        exp_load = 1'b0;
        if (!rst_n) begin
            ptr = 0; free_at = 0; last_load = -100;
            gid_now = 0; gid_last = 0; exp_busy = 1'b0;
            gq.delete();
            bq.delete();
        end else begin
            exp_busy = (cyc - last_load >= 1) && (cyc - last_load <= W + 1);
            gid_now = gid_last;
            if (cyc >= free_at && a.enable && (|a.req_valid)) begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    id = (ptr + k) % N;
                    if (win < 0 && a.req_valid[id]) win = id;
                end
                d = a.req_data[win*W +: W];
                exp_ready[win] = 1'b1;
                exp_load = 1'b1;
                gq.push_back('{id: win, data: d});
                for (int bi = W - 1; bi >= 0; bi--)
                    bq.push_back('{bit_v: d[bi], last: (bi == 0)});
                free_at = cyc + W + 1;
                last_load = cyc;
                gid_last = win;
                ptr = (win + 1) % N;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queues.
    always begin
        gexp_t g;
        bexp_t bb;
        @(negedge clk);
        #1;
        check("req_ready", 32'(a.req_ready), 32'(exp_ready));
        check("piso_load", 32'(a.piso_load), 32'(exp_load));
        if (a.piso_load) begin
            if (gq.size() == 0) begin
                check("load_unexpected", 32'(a.piso_load), 0);
            end else begin
                g = gq.pop_front();
                check("piso_data", 32'(a.piso_data), 32'(g.data));
            end
        end else begin
            check("piso_data_idle", 32'(a.piso_data), 0);
        end
        check("busy", 32'(a.busy), 32'(exp_busy));
        check("grant_id", 32'(a.grant_id), 32'(gid_now));
        if (a.ser_valid) begin
            if (bq.size() == 0) begin
                check("ser_unexpected", 32'(a.ser_valid), 0);
            end else begin
                bb = bq.pop_front();
                check("ser_bit", 32'(dout), 32'(bb.bit_v));
                check("ser_last", 32'(a.ser_last), 32'(bb.last));
            end
        end else begin
            check("ser_last_idle", 32'(a.ser_last), 0);
        end
    end

    // Side DUT with two gap cycles: req0 always valid.
    int last_b = -1, loads_b = 0;
    logic hs_b = 1'b0;
    always begin
        @(negedge clk);
        #1;
        hs_b = b.req_valid[0] & b.req_ready[0];
        if (!rst_n) begin
            last_b = -1;
        end else begin
            if (b.ser_valid && last_b >= 0)
                check("gap_quiet", 32'((cyc - last_b) <= W + 1), 1);
            if (b.piso_load) begin
                if (last_b >= 0)
                    check("gap_spacing", 32'(cyc - last_b), 32'(W + 3));
                last_b = cyc;
                loads_b++;
            end
        end
    end
    always @(posedge clk) begin
        #1;
        if (hs_b) b.req_data[W-1:0] = W'($urandom);
    end

    // mode 0: hold; 1: re-raise every request; 2: random valid/enable
    task automatic step(input int mode);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) a.req_valid[i] = 1'b0;
            if (!a.req_valid[i] &&
                (mode == 1 || (mode == 2 && $urandom_range(2) == 0))) begin
                a.req_valid[i] = 1'b1;
                a.req_data[i*W +: W] = W'($urandom);
            end
        end
        if (mode == 2) a.enable = ($urandom_range(7) != 0);
    endtask

    task automatic wait_busy();
        int t;
        t = 0;
        while (!a.busy && t < 12) begin
            step(1);
            t++;
        end
        check("wait_busy", 32'(a.busy), 1);
    endtask

    initial begin
        a.enable = 1'b0; a.req_valid = '0; a.req_data = '0;
        b.enable = 1'b1; b.req_valid = 2'b01; b.req_data = 8'h0B;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Lone req1 with pointer at 0.
        a.enable = 1'b1;
        a.req_valid = 2'b10;
        a.req_data = 8'hA0;
        repeat (8) step(0);

        // Single word 1011 on req0.
        a.req_valid = 2'b01;
        a.req_data = 8'h0B;
        repeat (8) step(0);

        // Both valid continuously: alternating grants.
        repeat (22) step(1);

        // Drop enable two cycles after a load.
        wait_busy();
        step(1);
        a.enable = 1'b0;
        repeat (12) step(1);
        a.enable = 1'b1;
        repeat (6) step(1);

        repeat (600) step(2);

        // Asynchronous reset between edges in the middle of a word.
        a.enable = 1'b1;
        wait_busy();
        step(1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(a.req_ready), 0);
        check("rst_load", 32'(a.piso_load), 0);
        check("rst_pdata", 32'(a.piso_data), 0);
        check("rst_sv", 32'(a.ser_valid), 0);
        check("rst_sl", 32'(a.ser_last), 0);
        check("rst_gid", 32'(a.grant_id), 0);
        check("rst_busy", 32'(a.busy), 0);
        check("rst_busy_gap", 32'(b.busy), 0);
        check("rst_load_gap", 32'(b.piso_load), 0);
        @(posedge clk);
        #1;
        a.req_valid = 2'b11;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (14) step(1);

        // Drain and confirm every predicted word came out.
        a.enable = 1'b0;
        repeat (12) step(0);
        check("grants_drained", 32'(gq.size()), 0);
        check("bits_drained", 32'(bq.size()), 0);
        check("gap_loads_seen", 32'(loads_b > 10), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
